// File: rtl/rv32i_decoder_header.sv
// Shared ALU opcode and operand-select definitions for the
// RV32IM decoder and the EX-stage execute unit.
package rv32i_decoder_header;

  localparam int ALU_OP_WIDTH = 5;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 5'd0;
  localparam alu_op_t ALU_SUB    = 5'd1;
  localparam alu_op_t ALU_SLL    = 5'd2;
  localparam alu_op_t ALU_SLT    = 5'd3;
  localparam alu_op_t ALU_SLTU   = 5'd4;
  localparam alu_op_t ALU_XOR    = 5'd5;
  localparam alu_op_t ALU_SRL    = 5'd6;
  localparam alu_op_t ALU_SRA    = 5'd7;
  localparam alu_op_t ALU_OR     = 5'd8;
  localparam alu_op_t ALU_AND    = 5'd9;
  localparam alu_op_t ALU_PASSB  = 5'd10;

  localparam alu_op_t ALU_EQ     = 5'd16;
  localparam alu_op_t ALU_NEQ    = 5'd17;
  localparam alu_op_t ALU_LT     = 5'd18;
  localparam alu_op_t ALU_GE     = 5'd19;
  localparam alu_op_t ALU_LTU    = 5'd20;
  localparam alu_op_t ALU_GEU    = 5'd21;

  localparam alu_op_t ALU_MUL    = 5'd24;
  localparam alu_op_t ALU_MULH   = 5'd25;
  localparam alu_op_t ALU_MULHSU = 5'd26;
  localparam alu_op_t ALU_MULHU  = 5'd27;

  localparam logic       ALU_SRC_A_REG  = 1'b0;
  localparam logic       ALU_SRC_A_PC   = 1'b1;

  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;
  localparam logic [1:0] ALU_SRC_B_ZERO = 2'b11;

endpackage

// File: rtl/rv32i_alu_mul.sv
// Combinational multiplier with per-operand signedness.
// Only built when RV32I_ALU_MUL_EN is defined.
`ifdef RV32I_ALU_MUL_EN
module rv32i_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  // Low 2W bits of the extended product are exact for all sign mixes.
  assign a_ext = {{WIDTH{a_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b_signed & b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;

endmodule
`endif

// File: rtl/rv32i_alu.sv
// EX-stage integer execute unit, one registered op per cycle.
// Define RV32I_ALU_MUL_EN to build the MUL/MULH/MULHSU/MULHU ops.
module rv32i_alu
  import rv32i_decoder_header::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] i_alu_op,
  input  logic                    i_alu_src_a,
  input  logic [1:0]              i_alu_src_b,
  input  logic [WIDTH-1:0]        i_rs1_data,
  input  logic [WIDTH-1:0]        i_rs2_data,
  input  logic [WIDTH-1:0]        i_pc,
  input  logic [WIDTH-1:0]        i_imm,
  output logic [WIDTH-1:0]        o_result,
  output logic                    o_take_branch
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]        op_a;
  logic [WIDTH-1:0]        op_b;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] sra_res;
  logic                    eq;
  logic                    lt_s;
  logic                    lt_u;
  logic [WIDTH-1:0]        res_d;
  logic                    br_d;

  always_comb begin
    op_a = (i_alu_src_a == ALU_SRC_A_PC) ? i_pc : i_rs1_data;
    case (i_alu_src_b)
      ALU_SRC_B_REG:  op_b = i_rs2_data;
      ALU_SRC_B_IMM:  op_b = i_imm;
      ALU_SRC_B_FOUR: op_b = WIDTH'(4);
      default:        op_b = '0;
    endcase
  end

  assign shamt   = op_b[SHW-1:0];
  assign sra_res = $signed(op_a) >>> shamt;
  assign eq      = (op_a == op_b);
  assign lt_s    = ($signed(op_a) < $signed(op_b));
  assign lt_u    = (op_a < op_b);

`ifdef RV32I_ALU_MUL_EN
  logic [2*WIDTH-1:0] product;

  rv32i_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a        (op_a),
    .b        (op_b),
    .a_signed ((i_alu_op == ALU_MULH) || (i_alu_op == ALU_MULHSU)),
    .b_signed (i_alu_op == ALU_MULH),
    .product  (product)
  );
`endif

  always_comb begin
    res_d = '0;
    br_d  = 1'b0;
    unique case (1'b1)
      (i_alu_op == ALU_ADD):   res_d = op_a + op_b;
      (i_alu_op == ALU_SUB):   res_d = op_a - op_b;
      (i_alu_op == ALU_SLL):   res_d = op_a << shamt;
      (i_alu_op == ALU_SLT):   res_d = WIDTH'(lt_s);
      (i_alu_op == ALU_SLTU):  res_d = WIDTH'(lt_u);
      (i_alu_op == ALU_XOR):   res_d = op_a ^ op_b;
      (i_alu_op == ALU_SRL):   res_d = op_a >> shamt;
      (i_alu_op == ALU_SRA):   res_d = sra_res;
      (i_alu_op == ALU_OR):    res_d = op_a | op_b;
      (i_alu_op == ALU_AND):   res_d = op_a & op_b;
      (i_alu_op == ALU_PASSB): res_d = op_b;
      (i_alu_op == ALU_EQ):    br_d  = eq;
      (i_alu_op == ALU_NEQ):   br_d  = !eq;
      (i_alu_op == ALU_LT):    br_d  = lt_s;
      (i_alu_op == ALU_GE):    br_d  = !lt_s;
      (i_alu_op == ALU_LTU):   br_d  = lt_u;
      (i_alu_op == ALU_GEU):   br_d  = !lt_u;
`ifdef RV32I_ALU_MUL_EN
      (i_alu_op == ALU_MUL):    res_d = product[WIDTH-1:0];
      (i_alu_op == ALU_MULH),
      (i_alu_op == ALU_MULHSU),
      (i_alu_op == ALU_MULHU):  res_d = product[2*WIDTH-1:WIDTH];
`endif
      default: begin
        res_d = '0;
        br_d  = 1'b0;
      end
    endcase
    // Branch ops report the condition on the result bus as well.
    if (br_d) res_d = WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_result      <= '0;
      o_take_branch <= 1'b0;
    end else begin
      o_result      <= res_d;
      o_take_branch <= br_d;
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu.
// Expectations follow RV32I_ALU_MUL_EN when it is defined.
module tb_rv32i_alu;
  import rv32i_decoder_header::*;

  logic        clk;
  logic        rst;
  logic [4:0]  alu_op;
  logic        src_a;
  logic [1:0]  src_b;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_branch;

  int checks = 0;
  int errors = 0;

  rv32i_alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_alu_op      (alu_op),
    .i_alu_src_a   (src_a),
    .i_alu_src_b   (src_b),
    .i_rs1_data    (rs1),
    .i_rs2_data    (rs2),
    .i_pc          (pc),
    .i_imm         (imm),
    .o_result      (result),
    .o_take_branch (take_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run(input logic [4:0] op, input logic sa,
                     input logic [1:0] sb, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] p,
                     input logic [31:0] im);
    alu_op = op;
    src_a  = sa;
    src_b  = sb;
    rs1    = a;
    rs2    = b;
    pc     = p;
    imm    = im;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp_res,
                       input logic exp_br);
    checks++;
    assert (result === exp_res) else begin
      errors++;
      $error("FAIL %s result: got %h want %h", tag, result, exp_res);
    end
    checks++;
    assert (take_branch === exp_br) else begin
      errors++;
      $error("FAIL %s branch: got %b want %b", tag, take_branch, exp_br);
    end
  endtask

  localparam logic RA = ALU_SRC_A_REG;
  localparam logic PA = ALU_SRC_A_PC;
  localparam logic [1:0] RB = ALU_SRC_B_REG;
  localparam logic [1:0] IB = ALU_SRC_B_IMM;
  localparam logic [1:0] FB = ALU_SRC_B_FOUR;
  localparam logic [1:0] ZB = ALU_SRC_B_ZERO;

  initial begin
    rst = 1'b1;
    run(ALU_ADD, RA, RB, 32'd5, 32'd5, 32'd0, 32'd0);
    check("reset", 32'd0, 1'b0);
    rst = 1'b0;

    run(ALU_ADD, RA, RB, 32'd1, 32'd2, 32'h0, 32'h0);
    check("add_rr", 32'd3, 1'b0);
    run(ALU_ADD, RA, IB, 32'd1, 32'd2, 32'h0, 32'd5);
    check("add_imm", 32'd6, 1'b0);
    run(ALU_ADD, PA, FB, 32'd1, 32'd2, 32'h100, 32'd5);
    check("pc_plus4", 32'h104, 1'b0);
    run(ALU_ADD, RA, ZB, 32'd7, 32'd2, 32'h100, 32'd5);
    check("add_zero", 32'd7, 1'b0);
    run(ALU_SUB, RA, RB, 32'd1, 32'd2, 32'h0, 32'h0);
    check("sub", 32'hFFFFFFFF, 1'b0);

    run(ALU_EQ, RA, RB, 32'd1, 32'd2, 32'h0, 32'h0);
    check("eq_ne", 32'd0, 1'b0);
    run(ALU_NEQ, RA, RB, 32'd1, 32'd2, 32'h0, 32'h0);
    check("neq", 32'd1, 1'b1);
    run(ALU_EQ, RA, RB, 32'd9, 32'd9, 32'h0, 32'h0);
    check("eq_eq", 32'd1, 1'b1);
    run(ALU_LT, RA, RB, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    check("lt", 32'd1, 1'b1);
    run(ALU_GE, RA, RB, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    check("ge", 32'd0, 1'b0);
    run(ALU_LTU, RA, RB, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    check("ltu", 32'd0, 1'b0);
    run(ALU_GEU, RA, RB, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    check("geu", 32'd1, 1'b1);

    run(ALU_SRA, RA, RB, 32'h80000000, 32'd4, 32'h0, 32'h0);
    check("sra", 32'hF8000000, 1'b0);
    run(ALU_SRL, RA, RB, 32'h80000000, 32'd4, 32'h0, 32'h0);
    check("srl", 32'h08000000, 1'b0);
    run(ALU_SLL, RA, RB, 32'h00000003, 32'h00000024, 32'h0, 32'h0);
    check("sll_mask", 32'h00000030, 1'b0);
    run(ALU_SLT, RA, RB, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    check("slt", 32'd1, 1'b0);
    run(ALU_SLTU, RA, RB, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    check("sltu", 32'd0, 1'b0);

    run(ALU_XOR, RA, RB, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    check("xor", 32'h0FF00FF0, 1'b0);
    run(ALU_OR, RA, RB, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    check("or", 32'hFFF0FFF0, 1'b0);
    run(ALU_AND, RA, RB, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    check("and", 32'hF000F000, 1'b0);
    run(ALU_PASSB, RA, IB, 32'h1234, 32'h0, 32'h0, 32'hABCDE000);
    check("passb", 32'hABCDE000, 1'b0);
    run(5'd11, RA, RB, 32'd1, 32'd2, 32'h0, 32'h0);
    check("unused", 32'd0, 1'b0);

`ifdef RV32I_ALU_MUL_EN
    run(ALU_MULHU, RA, RB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    check("mulhu", 32'hFFFFFFFE, 1'b0);
    run(ALU_MUL, RA, RB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    check("mul", 32'h00000001, 1'b0);
    run(ALU_MULH, RA, RB, 32'h80000000, 32'd2, 32'h0, 32'h0);
    check("mulh", 32'hFFFFFFFF, 1'b0);
    run(ALU_MULHU, RA, RB, 32'h80000000, 32'd2, 32'h0, 32'h0);
    check("mulhu2", 32'h00000001, 1'b0);
    run(ALU_MULHSU, RA, RB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    check("mulhsu", 32'hFFFFFFFF, 1'b0);
`else
    run(ALU_MULHU, RA, RB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    check("mulhu_off", 32'd0, 1'b0);
    run(ALU_MUL, RA, RB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    check("mul_off", 32'd0, 1'b0);
    run(ALU_MULH, RA, RB, 32'h80000000, 32'd2, 32'h0, 32'h0);
    check("mulh_off", 32'd0, 1'b0);
`endif

    run(ALU_NEQ, RA, RB, 32'd3, 32'd4, 32'h0, 32'h0);
    check("pre_rst", 32'd1, 1'b1);
    rst = 1'b1;
    run(ALU_NEQ, RA, RB, 32'd3, 32'd4, 32'h0, 32'h0);
    check("mid_rst", 32'd0, 1'b0);
    rst = 1'b0;
    run(ALU_ADD, RA, RB, 32'd10, 32'd20, 32'h0, 32'h0);
    check("post_rst", 32'd30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
